// File: rtl/sfx_priority_player_pkg.sv
// Shared definitions for the sound-effect sequencer: FSM state encoding,
// symbolic channel indices and a small width helper.
package sfx_priority_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_t;

  // Channel roles; a higher index has higher priority.
  localparam int CH_FIRE  = 0;
  localparam int CH_HIT   = 1;
  localparam int CH_CLEAR = 2;
  localparam int CH_BOSS  = 3;

  // $clog2 clamped to at least one bit, so that single-value counters still
  // get a real vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator for the buzzer.
//  clk, reset   : system clock, synchronous active-high reset
//  load         : restart the tone: buzz goes high, counter reloads
//  run          : keep toggling; when both load and run are low, buzz is forced low
//  half_period  : half-period in clk cycles (0 behaves like 1)
//  buzz         : registered square-wave output
module sfx_tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            run,
  input  logic [HP_W-1:0] half_period,
  output logic            buzz
);

  logic [HP_W-1:0] r_cnt;
  logic            r_buzz;
  logic [HP_W-1:0] w_reload;

  // A half-period of 0 reloads 0, so it toggles every cycle, the same as 1.
  assign w_reload = (half_period == '0) ? '0 : half_period - HP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_buzz <= 1'b0;
    end else if (load) begin
      r_cnt  <= w_reload;
      r_buzz <= 1'b1;
    end else if (run) begin
      if (r_cnt == '0) begin
        r_cnt  <= w_reload;
        r_buzz <= ~r_buzz;
      end else begin
        r_cnt  <= r_cnt - HP_W'(1);
      end
    end else begin
      r_buzz <= 1'b0;
    end
  end

  assign buzz = r_buzz;

endmodule

// File: rtl/sfx_priority_player.sv
// Multi-channel sound-effect sequencer that drives a single piezo buzzer.
// Each channel has its own tone and duration. A higher channel index preempts
// a lower one. Lower-priority requests are queued, one pending bit per channel.
//  clk        : system clock
//  reset      : synchronous, active-high
//  enable     : master sound enable; when low, the block goes silent and forgets pending requests
//  trigger    : per-channel request; a rising edge requests that channel
//  buzz       : square-wave drive
//  busy       : high while a tone or its trailing gap is in progress
//  active_ch  : channel being played (valid while busy)
//  done       : one-cycle pulse when a tone runs its full duration
//  done_ch    : channel that completed (valid with done)
module sfx_priority_player
  import sfx_priority_player_pkg::*;
#(
  parameter int                          CH_COUNT    = 4,
  parameter int                          HP_W        = 20,
  parameter int                          DUR_W       = 8,
  parameter int                          TICK_CYCLES = 100000,
  parameter logic [CH_COUNT*HP_W-1:0]    HALF_PERIOD = {20'd37500, 20'd50000, 20'd75000, 20'd100000},
  parameter logic [CH_COUNT*DUR_W-1:0]   DURATION    = {8'd200, 8'd120, 8'd40, 8'd60},
  parameter int                          GAP_TICKS   = 2,
  localparam int                         CH_W        = clog2_min1(CH_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CH_COUNT-1:0] trigger,
  output logic                buzz,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch,
  output logic                done,
  output logic [CH_W-1:0]     done_ch
);

  localparam int TICK_W = clog2_min1(TICK_CYCLES);
  localparam int GAP_W  = clog2_min1(GAP_TICKS + 1);

  sfx_state_t          r_state, w_state_nxt;
  logic [CH_COUNT-1:0] r_trig_prev, r_pending, w_pend_nxt, w_rise, w_dur_nz;
  logic [CH_W-1:0]     r_active_ch, r_done_ch, w_sel_ch;
  logic                w_sel_any;
  logic [DUR_W-1:0]    r_dur, w_sel_dur;
  logic [HP_W-1:0]     w_sel_hp, w_act_hp;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic                r_done;
  logic                w_tick, w_last, w_load, w_done_set, w_run;

  // Edge detection, priority encoding and per-channel parameter lookup.
  always_comb begin
    w_rise    = trigger & ~r_trig_prev;
    w_sel_any = |r_pending;
    w_sel_ch  = '0;
    w_sel_hp  = '0;
    w_sel_dur = '0;
    w_act_hp  = '0;
    w_dur_nz  = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (r_pending[c]) w_sel_ch = CH_W'(c);
      w_dur_nz[c] = (DURATION[c*DUR_W +: DUR_W] != '0);
    end
    for (int c = 0; c < CH_COUNT; c++) begin
      if (CH_W'(c) == w_sel_ch) begin
        w_sel_hp  = HALF_PERIOD[c*HP_W +: HP_W];
        w_sel_dur = DURATION[c*DUR_W +: DUR_W];
      end
      if (CH_W'(c) == r_active_ch) w_act_hp = HALF_PERIOD[c*HP_W +: HP_W];
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign w_last = w_tick && (r_dur == DUR_W'(1));

  // Next-state logic. A (re)load always beats completion on the same cycle,
  // so a tone cut off on its final tick does not report done.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_any) w_load = 1'b1;
      end
      ST_PLAY: begin
        // ">=" lets a retrigger of the active channel restart it.
        if (w_sel_any && (w_sel_ch >= r_active_ch)) begin
          w_load = 1'b1;
        end else if (w_last) begin
          w_done_set  = 1'b1;
          w_state_nxt = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_sel_any && (w_sel_ch > r_active_ch)) begin
          w_load = 1'b1;
        end else if (w_tick && (r_gap == GAP_W'(1))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load) w_state_nxt = ST_PLAY;
    if (!enable) begin
      w_load      = 1'b0;
      w_done_set  = 1'b0;
      w_state_nxt = ST_IDLE;
    end

    w_pend_nxt = r_pending;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (w_load && (CH_W'(c) == w_sel_ch)) w_pend_nxt[c] = 1'b0;
    end
    // A new edge wins over the clear of the channel being loaded.
    w_pend_nxt = w_pend_nxt | (w_rise & w_dur_nz);
    if (!enable) w_pend_nxt = '0;
  end

  assign w_run = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY) && !w_load;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_prev <= trigger;  // a trigger held high through reset gives no edge
      r_pending   <= '0;
      r_active_ch <= '0;
      r_done      <= 1'b0;
      r_done_ch   <= '0;
      r_dur       <= '0;
      r_tick_cnt  <= '0;
      r_gap       <= '0;
    end else begin
      r_trig_prev <= trigger;
      r_pending   <= w_pend_nxt;
      r_done      <= w_done_set;
      if (w_done_set) r_done_ch <= r_active_ch;
      if (w_load) begin
        r_active_ch <= w_sel_ch;
        r_dur       <= w_sel_dur;
        r_tick_cnt  <= '0;  // tick phase aligned to tone start
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        if ((r_state == ST_PLAY) && w_tick) r_dur <= r_dur - DUR_W'(1);
      end
      // The prescaler wraps on the final play tick, so the gap gets whole ticks.
      if (w_done_set)                          r_gap <= GAP_W'(GAP_TICKS);
      else if ((r_state == ST_GAP) && w_tick)  r_gap <= r_gap - GAP_W'(1);
    end
  end

  sfx_tone_gen #(.HP_W(HP_W)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .load        (w_load),
    .run         (w_run),
    .half_period (w_load ? w_sel_hp : w_act_hp),
    .buzz        (buzz)
  );

  assign busy      = (r_state != ST_IDLE);
  assign active_ch = r_active_ch;
  assign done      = r_done;
  assign done_ch   = r_done_ch;

endmodule

// File: tb/tb_sfx_priority_player.sv
module tb_sfx_priority_player;
  import sfx_priority_player_pkg::*;

  localparam int T = 10;
  localparam int G = 1;
  localparam logic [79:0] HP = {20'd3, 20'd4, 20'd5, 20'd2};
  localparam logic [31:0] DU = {8'd5, 8'd2, 8'd4, 8'd3};

  int hpv[4] = '{2, 5, 4, 3};
  int duv[4] = '{3, 4, 2, 5};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] trigger = 4'b0;
  logic       buzz, busy, done;
  logic [1:0] active_ch, done_ch;

  int errors = 0;
  int checks = 0;

  sfx_priority_player #(
    .CH_COUNT(4), .HP_W(20), .DUR_W(8), .TICK_CYCLES(T),
    .HALF_PERIOD(HP), .DURATION(DU), .GAP_TICKS(G)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .buzz(buzz), .busy(busy), .active_ch(active_ch), .done(done), .done_ch(done_ch)
  );

  always #5 clk = ~clk;

  // Reference model: the mode, the channel being played, the cycles elapsed since
  // the tone started and the gap cycles left. buzz is derived arithmetically from the elapsed time.
  int       m_mode = 0;  // 0 idle, 1 play, 2 gap
  int       m_ch = 0, m_el = 0, m_gap = 0, m_done_ch = 0;
  bit [3:0] m_pend = 0, m_prev = 0;
  bit       m_buzz = 0, m_done = 0;

  task automatic model_step();
    int hi, hp;
    bit [3:0] rise;
    bit ld;
    m_done = 0;
    if (reset) begin
      m_mode = 0; m_pend = 0; m_buzz = 0; m_ch = 0; m_done_ch = 0; m_prev = trigger;
      return;
    end
    rise = trigger & ~m_prev;
    m_prev = trigger;
    if (!enable) begin
      m_mode = 0; m_pend = 0; m_buzz = 0;
      return;
    end
    hi = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) hi = i;
    ld = (hi >= 0) && ((m_mode == 0) || (m_mode == 1 && hi >= m_ch) || (m_mode == 2 && hi > m_ch));
    if (ld) begin
      m_pend[hi] = 0; m_mode = 1; m_ch = hi; m_el = 0; m_buzz = 1;
    end else if (m_mode == 1) begin
      m_el++;
      if (m_el == duv[m_ch] * T) begin
        m_done = 1; m_done_ch = m_ch; m_buzz = 0;
        m_mode = (G > 0) ? 2 : 0;
        m_gap = G * T;
      end else begin
        hp = (hpv[m_ch] == 0) ? 1 : hpv[m_ch];
        m_buzz = ((m_el / hp) % 2) == 0;
      end
    end else if (m_mode == 2) begin
      m_gap--;
      if (m_gap == 0) m_mode = 0;
    end
    for (int i = 0; i < 4; i++) if (rise[i] && duv[i] != 0) m_pend[i] = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [6:0] got_vec();
    return {buzz, busy, done, (busy === 1'b1) ? active_ch : 2'b00, (done === 1'b1) ? done_ch : 2'b00};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [1:0] a, d;
    a = (m_mode != 0) ? 2'(m_ch) : 2'b00;
    d = m_done ? 2'(m_done_ch) : 2'b00;
    return {m_buzz, m_mode != 0, m_done, a, d};
  endfunction

  task automatic settle();
    trigger = 4'b0;
    repeat (100) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = 4'b0; enable = 1'b1;
    repeat (3) tick();
    checks++;
    if ({buzz, busy, done, active_ch, done_ch} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {buzz, busy, done, active_ch, done_ch}, 7'b0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int done_at = -1, idle_at = -1;
    trigger = 4'(1 << CH_FIRE);
    tick();
    trigger = 4'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_pending busy=%b exp=0", busy); end
    tick();
    checks++;
    if ({buzz, busy, active_ch} !== {1'b1, 1'b1, 2'd0}) begin
      errors++; $display("FAIL single_load got=%b exp=%b", {buzz, busy, active_ch}, 4'b1100);
    end
    for (int n = 1; n <= 60; n++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL single cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      if (busy === 1'b0 && idle_at < 0) idle_at = n;
    end
    checks++;
    if (done_at !== 30) begin errors++; $display("FAIL single_done_time got=%0d exp=30", done_at); end
    checks++;
    if (idle_at !== 40) begin errors++; $display("FAIL single_idle_time got=%0d exp=40", idle_at); end
  endtask

  task automatic test_simultaneous();
    int dn = 0;
    int d_at[2] = '{-1, -1};
    logic [1:0] d_ch[2] = '{2'b0, 2'b0};
    trigger = 4'((1 << CH_FIRE) | (1 << CH_CLEAR));
    tick();
    trigger = 4'b0;
    tick();
    checks++;
    if (active_ch !== 2'd2) begin errors++; $display("FAIL simul_first got=%0d exp=2", active_ch); end
    for (int n = 1; n <= 90; n++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (done === 1'b1) begin
        if (dn < 2) begin d_at[dn] = n; d_ch[dn] = done_ch; end
        dn++;
      end
    end
    checks++;
    if (dn !== 2 || d_at[0] !== 20 || d_ch[0] !== 2'd2 || d_at[1] !== 61 || d_ch[1] !== 2'd0) begin
      errors++;
      $display("FAIL simul_dones got n=%0d %0d@%0d %0d@%0d exp n=2 2@20 0@61", dn, d_ch[0], d_at[0], d_ch[1], d_at[1]);
    end
  endtask

  task automatic test_preempt();
    int dn = 0, d_at = -1;
    logic [1:0] d_ch = 2'b0;
    trigger = 4'(1 << CH_HIT);
    tick();
    trigger = 4'b0;
    tick();
    for (int n = 1; n <= 80; n++) begin
      trigger = (n == 15) ? 4'(1 << CH_BOSS) : 4'b0;
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL preempt cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (n == 16) begin
        checks++;
        if (active_ch !== 2'd3) begin errors++; $display("FAIL preempt_switch got=%0d exp=3", active_ch); end
      end
      if (done === 1'b1) begin dn++; d_at = n; d_ch = done_ch; end
    end
    checks++;
    if (dn !== 1 || d_at !== 66 || d_ch !== 2'd3) begin
      errors++; $display("FAIL preempt_done got n=%0d ch=%0d at=%0d exp n=1 ch=3 at=66", dn, d_ch, d_at);
    end
  endtask

  task automatic test_retrigger();
    int dn = 0, d_at = -1;
    trigger = 4'(1 << CH_HIT);
    tick();
    trigger = 4'b0;
    tick();
    for (int n = 1; n <= 90; n++) begin
      trigger = (n == 29) ? 4'(1 << CH_HIT) : 4'b0;
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL retrig cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (done === 1'b1) begin dn++; d_at = n; end
    end
    checks++;
    if (dn !== 1 || d_at !== 70) begin
      errors++; $display("FAIL retrig_done got n=%0d at=%0d exp n=1 at=70", dn, d_at);
    end
  endtask

  task automatic test_enable();
    int busy_cnt = 0;
    trigger = 4'(1 << CH_CLEAR);
    tick();
    trigger = 4'b0;
    tick();
    for (int n = 1; n <= 40; n++) begin
      trigger = (n == 1) ? 4'(1 << CH_FIRE) : (n == 7) ? 4'(1 << CH_HIT) : 4'b0;
      enable  = !(n >= 5 && n < 10);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL enable cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (n == 5) begin
        checks++;
        if ({buzz, busy, done} !== 3'b000) begin
          errors++; $display("FAIL enable_drop got=%b exp=000", {buzz, busy, done});
        end
      end
      if (n >= 5 && busy !== 1'b0) busy_cnt++;
    end
    enable = 1'b1;
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("FAIL enable_quiet busy_cycles=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    int busy_cnt = 0;
    trigger = 4'(1 << CH_HIT);
    tick();
    tick();
    for (int n = 1; n <= 40; n++) begin
      trigger = (n == 31) ? 4'b0 : 4'(1 << CH_HIT);
      reset   = (n >= 5 && n < 8);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL rstmid cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
      if (n == 5) begin
        checks++;
        if ({buzz, busy, done, active_ch, done_ch} !== 7'b0) begin
          errors++; $display("FAIL rstmid_zero got=%b exp=0000000", {buzz, busy, done, active_ch, done_ch});
        end
      end
      if (n >= 5 && n <= 32 && busy !== 1'b0) busy_cnt++;
      if (n == 33) begin
        checks++;
        if ({busy, active_ch} !== 3'b101) begin
          errors++; $display("FAIL rstmid_rearm got=%b exp=101", {busy, active_ch});
        end
      end
    end
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("FAIL rstmid_quiet busy_cycles=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 29) == 0) trigger[i] = ~trigger[i];
      if (enable) begin
        if ($urandom_range(0, 399) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        enable = 1'b1;
      end
      reset = ($urandom_range(0, 1499) == 0);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
    end
    reset = 1'b0; enable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    settle(); test_single();
    settle(); test_simultaneous();
    settle(); test_preempt();
    settle(); test_retrigger();
    settle(); test_enable();
    settle(); test_reset_mid();
    settle(); test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
